lsu_port: RTL and testbench

Load/store initiator that sits between the hart's execute stage and the byte-enabled single-port `ram`. It accepts one load or store request at a time and drives the RAM's address, width, write-enable and data lines. Loads are sign- or zero-extended. A load that crosses a 32-bit word boundary is split into two RAM reads and merged. Stores that cross a word boundary and out-of-range addresses return a fault instead of accessing RAM.

---
 rtl/lsu_port_pkg.sv | 36 +++
 rtl/lsu_port_if.sv | 28 ++
 rtl/lsu_port_load_extend.sv | 22 ++
 rtl/ram.sv | 46 ++++
 rtl/lsu_port.sv | 175 +++++++++++++++++
 tb/tb_lsu_port.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/lsu_port_pkg.sv
// Shared ISA-level types for the load/store path: data widths, LSU fault codes
// and the LSU sequencing states.
package isa_types;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        write_byte = 2'd0,
        write_half = 2'd1,
        write_word = 2'd2
    } write_width_t;

    typedef enum logic [1:0] {
        FAULT_NONE             = 2'd0,
        FAULT_MISALIGNED_STORE = 2'd1,
        FAULT_ACCESS           = 2'd2
    } lsu_fault_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_LO = 3'd1,
        ISSUE_HI = 3'd2,
        WAIT     = 3'd3,
        RESP     = 3'd4
    } lsu_state_t;

    function automatic logic [2:0] width_bytes(write_width_t w);
        case (w)
            write_byte: width_bytes = 3'd1;
            write_half: width_bytes = 3'd2;
            write_word: width_bytes = 3'd4;
            default:    width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_port_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store port (slave).
interface lsu_port_if;
    import isa_types::*;

    logic             req_valid;
    logic             req_ready;
    logic             req_store;
    write_width_t     req_width;
    logic             req_unsigned;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_rdata;
    lsu_fault_t       resp_fault;

    modport master (
        output req_valid, req_store, req_width, req_unsigned, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_store, req_width, req_unsigned, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );

endinterface

// File: rtl/lsu_port_load_extend.sv
// Sign/zero extension of right-aligned load data to XLEN.
module load_extend
    import isa_types::*;
(
    input  write_width_t    width,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] result
);

    // Replicate the top bit of the loaded field unless zero-extension is requested.
    always_comb begin
        result = raw;
        case (width)
            write_byte: result = {{(XLEN-8){~is_unsigned & raw[7]}}, raw[7:0]};
            write_half: result = {{(XLEN-16){~is_unsigned & raw[15]}}, raw[15:0]};
            write_word: result = raw;
            default:    result = raw;
        endcase
    end

endmodule

// File: rtl/ram.sv
// Byte-enabled single-port RAM: writes right-aligned data at a byte address,
// reads return the containing word shifted right by the byte offset one cycle later.
module ram
    import isa_types::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic            clock,
    input  logic [XLEN-1:0] addr,
    input  write_width_t    wwidth,
    input  logic            wenable,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]      mem_r [MEM_BYTES];
    logic [AW-1:0]   byte_s;
    logic [AW-1:0]   base_s;
    logic [2:0]      nbytes_s;
    logic [XLEN-1:0] word_s;
    logic            unused_hi_s;

    // Address decode and the word containing the addressed byte.
    always_comb begin
        byte_s   = addr[AW-1:0];
        base_s   = {addr[AW-1:2], 2'b00};
        nbytes_s = width_bytes(wwidth);
        word_s   = {mem_r[base_s + AW'(3)], mem_r[base_s + AW'(2)],
                    mem_r[base_s + AW'(1)], mem_r[base_s]};
    end

    assign unused_hi_s = ^addr[XLEN-1:AW];

    // Registered read and byte-lane write.
    always_ff @(posedge clock) begin
        rdata <= word_s >> {addr[1:0], 3'b000};
        for (int i = 0; i < 4; i++) begin
            if (wenable && (3'(i) < nbytes_s)) begin
                mem_r[byte_s + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/lsu_port.sv
// Load/store initiator: one request at a time, split loads across word
// boundaries, faults on out-of-range accesses and word-crossing stores.
module lsu_port
    import isa_types::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic            clock,
    input  logic            reset,
    lsu_port_if.slave       bus,
    output logic [XLEN-1:0] mem_addr,
    output write_width_t    mem_wwidth,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_BYTES);

    lsu_state_t      state_r;
    logic            store_r;
    logic            unsigned_r;
    logic            split_r;
    write_width_t    width_r;
    logic [XLEN-1:0] addr_r;
    logic [XLEN-1:0] lo_r;
    logic            req_ready_r;
    logic            resp_valid_r;
    logic [XLEN-1:0] resp_rdata_r;
    lsu_fault_t      resp_fault_r;
    logic [XLEN-1:0] mem_addr_r;
    write_width_t    mem_wwidth_r;
    logic            mem_wenable_r;
    logic [XLEN-1:0] mem_wdata_r;

    logic [2:0]      req_nbytes_s;
    logic [XLEN:0]   req_last_s;
    logic            req_cross_s;
    lsu_fault_t      req_fault_s;
    logic [1:0]      lo_lanes_s;
    logic [4:0]      merge_shift_s;
    logic [XLEN-1:0] lo_keep_s;
    logic [XLEN-1:0] merged_s;
    logic [XLEN-1:0] ext_s;

    // Fault classification of the incoming request; the extra top bit catches address wrap.
    always_comb begin
        req_nbytes_s = width_bytes(bus.req_width);
        req_last_s   = {1'b0, bus.req_addr} + {{(XLEN-2){1'b0}}, req_nbytes_s}
                       - {{XLEN{1'b0}}, 1'b1};
        req_cross_s  = ({1'b0, bus.req_addr[1:0]} + req_nbytes_s) > 3'd4;
        if (req_last_s >= MEM_LIMIT) begin
            req_fault_s = FAULT_ACCESS;
        end else if (bus.req_store && req_cross_s) begin
            req_fault_s = FAULT_MISALIGNED_STORE;
        end else begin
            req_fault_s = FAULT_NONE;
        end
    end

    // Split-load merge: low part keeps 4-off bytes, high word lands above it (shift <= 24).
    always_comb begin
        lo_lanes_s    = 2'(3'd4 - {1'b0, addr_r[1:0]});
        merge_shift_s = {lo_lanes_s, 3'b000};
        lo_keep_s     = mem_rdata & ({XLEN{1'b1}} >> {addr_r[1:0], 3'b000});
        if (split_r) begin
            merged_s = lo_r | (mem_rdata << merge_shift_s);
        end else begin
            merged_s = mem_rdata;
        end
    end

    load_extend u_load_extend (
        .width       (width_r),
        .is_unsigned (unsigned_r),
        .raw         (merged_s),
        .result      (ext_s)
    );

    // Request sequencing with all bus and RAM outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            store_r       <= 1'b0;
            unsigned_r    <= 1'b0;
            split_r       <= 1'b0;
            width_r       <= write_word;
            addr_r        <= {XLEN{1'b0}};
            lo_r          <= {XLEN{1'b0}};
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_rdata_r  <= {XLEN{1'b0}};
            resp_fault_r  <= FAULT_NONE;
            mem_addr_r    <= {XLEN{1'b0}};
            mem_wwidth_r  <= write_word;
            mem_wenable_r <= 1'b0;
            mem_wdata_r   <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_r <= 1'b0;
                        store_r     <= bus.req_store;
                        unsigned_r  <= bus.req_unsigned;
                        width_r     <= bus.req_width;
                        addr_r      <= bus.req_addr;
                        split_r     <= req_cross_s & ~bus.req_store;
                        if (req_fault_s != FAULT_NONE) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_fault_r <= req_fault_s;
                            resp_rdata_r <= {XLEN{1'b0}};
                        end else begin
                            state_r       <= ISSUE_LO;
                            mem_addr_r    <= bus.req_addr;
                            mem_wwidth_r  <= bus.req_width;
                            mem_wenable_r <= bus.req_store;
                            mem_wdata_r   <= bus.req_wdata;
                        end
                    end
                end
                ISSUE_LO: begin
                    mem_wenable_r <= 1'b0;
                    if (store_r) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_fault_r <= FAULT_NONE;
                        resp_rdata_r <= {XLEN{1'b0}};
                    end else if (split_r) begin
                        state_r      <= ISSUE_HI;
                        mem_addr_r   <= {addr_r[XLEN-1:2] + (XLEN-2)'(1), 2'b00};
                        mem_wwidth_r <= write_word;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                ISSUE_HI: begin
                    lo_r    <= lo_keep_s;
                    state_r <= WAIT;
                end
                WAIT: begin
                    resp_rdata_r <= ext_s;
                    resp_fault_r <= FAULT_NONE;
                    resp_valid_r <= 1'b1;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        resp_rdata_r <= {XLEN{1'b0}};
                        resp_fault_r <= FAULT_NONE;
                        req_ready_r  <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    req_ready_r   <= 1'b1;
                    resp_valid_r  <= 1'b0;
                    mem_wenable_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_fault = resp_fault_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wwidth     = mem_wwidth_r;
    assign mem_wenable    = mem_wenable_r;
    assign mem_wdata      = mem_wdata_r;

endmodule

// File: tb/tb_lsu_port.sv
// Scoreboard bench for lsu_port driving a real ram; expectations come from a
// byte-array memory model and the access rules.
module tb_lsu_port;
    import isa_types::*;

    localparam int MEM_BYTES = 1024;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    lsu_port_if bus ();

    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    write_width_t    mem_wwidth;
    logic            mem_wenable;

    lsu_port #(.MEM_BYTES(MEM_BYTES)) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .mem_addr    (mem_addr),
        .mem_wwidth  (mem_wwidth),
        .mem_wenable (mem_wenable),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    ram #(.MEM_BYTES(MEM_BYTES)) u_ram (
        .clock   (clock),
        .addr    (mem_addr),
        .wwidth  (mem_wwidth),
        .wenable (mem_wenable),
        .wdata   (mem_wdata),
        .rdata   (mem_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        lsu_fault_t  fault;
        int          lat;
        int          acc;
        bit          store;
        bit          split;
        logic [31:0] addr;
        int          stall;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  model_mem [MEM_BYTES];
    logic [31:0] addr_log [int];
    bit          we_log [int];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        addr_log[cyc] = mem_addr;
        we_log[cyc]   = mem_wenable;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(bit st, write_width_t w, bit u, logic [31:0] a,
                                   logic [31:0] d, int stall);
        exp_t        e;
        int          n;
        int          off;
        longint      last;
        logic [31:0] v;
        n    = (w == write_byte) ? 1 : (w == write_half) ? 2 : 4;
        off  = int'(a % 4);
        last = longint'(a) + longint'(n) - 1;
        e.addr = a; e.store = st; e.stall = stall; e.rdata = 32'd0; e.split = 1'b0; e.acc = 0;
        if (last >= MEM_BYTES) begin
            e.fault = FAULT_ACCESS; e.lat = 1;
        end else if (st && (off + n > 4)) begin
            e.fault = FAULT_MISALIGNED_STORE; e.lat = 1;
        end else if (st) begin
            for (int i = 0; i < n; i++) model_mem[int'(a) + i] = d[8*i +: 8];
            e.fault = FAULT_NONE; e.lat = 2;
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(a) + i]) << (8*i));
            if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            e.fault = FAULT_NONE; e.split = (off + n > 4); e.lat = e.split ? 4 : 3; e.rdata = v;
        end
        return e;
    endfunction

    function automatic logic [31:0] logged_addr(int c);
        return addr_log.exists(c) ? addr_log[c] : 32'hxxxx_xxxx;
    endfunction

    task automatic check_reset_vals(string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'(FAULT_NONE));
        check({tag, "_mem_wenable"}, 32'(mem_wenable), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_mem_wwidth"}, 32'(mem_wwidth), 32'(write_word));
    endtask

    task automatic issue(bit st, write_width_t w, bit u, logic [31:0] a, logic [31:0] d, int stall);
        exp_t e;
        int   n;
        @(negedge clock);
        bus.req_store = st; bus.req_width = w; bus.req_unsigned = u;
        bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (addr %h)", a);
            bus.req_valid = 1'b0;
            return;
        end
        e = model(st, w, u, a, d, stall);
        e.acc = cyc;
        sbq.push_back(e);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
        repeat (3) @(negedge clock);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    initial begin
        exp_t e;
        int   wc;
        bus.resp_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_resp: got valid expected none (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    wc = 0;
                    for (int c = e.acc + 1; c < cyc; c++) if (we_log.exists(c) && we_log[c]) wc++;
                    check("wenable_cycles", 32'(wc), (e.store && e.fault == FAULT_NONE) ? 32'd1 : 32'd0);
                    if (!e.store && e.fault == FAULT_NONE) begin
                        check("lo_read_addr", logged_addr(e.acc + 1), e.addr);
                        if (e.split) check("hi_read_addr", logged_addr(e.acc + 2), ((e.addr >> 2) + 32'd1) << 2);
                    end
                    if (e.stall > 0) begin
                        bus.resp_ready = 1'b0;
                        for (int k = 0; k < e.stall; k++) begin
                            @(negedge clock);
                            check("stall_valid", 32'(bus.resp_valid), 32'd1);
                            check("stall_rdata", bus.resp_rdata, e.rdata);
                            check("stall_fault", 32'(bus.resp_fault), 32'(e.fault));
                            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
                        end
                        bus.resp_ready = 1'b1;
                    end
                    @(negedge clock);
                    check("post_resp_valid", 32'(bus.resp_valid), 32'd0);
                    check("post_resp_req_ready", 32'(bus.req_ready), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          sel;
        int          n;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_width = write_word;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("post_rst");

        for (int i = 0; i < MEM_BYTES; i += 4) issue(1'b1, write_word, 1'b0, 32'(i), $urandom(), 0);

        issue(1'b1, write_word, 1'b0, 32'h10, 32'h8765_4321, 0);
        issue(1'b0, write_word, 1'b1, 32'h10, 32'd0, 0);
        issue(1'b0, write_byte, 1'b0, 32'h13, 32'd0, 0);
        issue(1'b0, write_half, 1'b1, 32'h11, 32'd0, 0);
        issue(1'b1, write_word, 1'b0, 32'h14, 32'hAABB_CCDD, 0);
        issue(1'b0, write_word, 1'b0, 32'h12, 32'd0, 0);
        issue(1'b1, write_half, 1'b0, 32'h17, 32'h0000_1234, 0);
        issue(1'b0, write_word, 1'b0, 32'h14, 32'd0, 0);
        issue(1'b0, write_word, 1'b0, 32'h3FE, 32'd0, 0);
        issue(1'b0, write_byte, 1'b0, 32'h3FF, 32'd0, 0);
        issue(1'b0, write_word, 1'b0, 32'h10, 32'd0, 5);
        drain();

        // Reset while a store sits in ISSUE_LO must block the write.
        @(negedge clock);
        bus.req_store = 1'b1; bus.req_width = write_word; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF; bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("abort_store_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        check("abort_store_wenable", 32'(mem_wenable), 32'd1);
        reset = 1'b1;
        #1 check_reset_vals("async_rst");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        issue(1'b0, write_word, 1'b0, 32'h20, 32'd0, 0);
        drain();

        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 32'($urandom_range(0, MEM_BYTES - 1));
            else if (sel == 8) a = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 3));
            else               a = $urandom();
            issue(1'($urandom_range(0, 2) == 0), write_width_t'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), a, $urandom(),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
